yd_wbq: RTL and testbench
=========================

YD_WBQ -- requirements
Module: yd_wbq

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write-back entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_valid, a_ready  input/output  1/1  ALU result handshake.
REQ-005 a_addr, a_data  input  4/16  ALU destination register address and result.
REQ-006 b_valid, b_ready  input/output  1/1  load-unit result handshake.
REQ-007 b_addr, b_data  input  4/16  load-unit destination address and data.
REQ-008 jpc  input  1  pipeline bubble; PC (addr 4'hF) writes may issue only while high.
REQ-009 we0, waddr0, din0  output  1/4/16  register-file write port 0.
REQ-010 we1, waddr1, din1  output  1/4/16  register-file write port 1.
REQ-011 raddr0, raddr1  input  4/4  hazard lookup addresses.
REQ-012 pend0, pend1  output  1/1  buffered write pending for raddr0/raddr1.
REQ-013 empty  output  1  no entries buffered.

Function
REQ-014 Storage: in-order circular FIFO of DEPTH entries {addr[3:0], data[15:0]}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-015 a_ready = (DEPTH - count) >= 1; b_ready = (DEPTH - count) >= 2; both use registered count only, not same-cycle drains.
REQ-016 Transfer occurs when valid && ready at a rising edge; data/addr sampled at that edge.
REQ-017 Both sources accepted in one cycle: A entry enqueued ahead of B entry (A older).
REQ-018 Accepted entries with addr 4'h0 are discarded, not stored, count unaffected.
REQ-019 Outputs are combinational from registered FIFO state plus jpc only; entry accepted at edge N can issue in the cycle after edge N (1-cycle latency), never same cycle.
REQ-020 Issue decision each cycle, h0 = oldest entry, h1 = second oldest (if count>=2):
  - count==0: we0=we1=0.
  - h0.addr==F and jpc==0: stall, no issue, no pop.
  - count==1, or h1.addr==F with jpc==0: issue h0 on port 0 only, pop 1.
  - h0.addr==h1.addr: coalesce, issue h1 on port 0 only, pop 2 (younger value wins).
  - otherwise: h0 on port 0, h1 on port 1, pop 2.
REQ-021 we1 is never asserted with waddr1==waddr0; we1 never asserted without we0.
REQ-022 When a port's we is 0 its waddr and din SHALL be 0.
REQ-023 Pops and pushes in the same cycle SHALL both take effect; count_next = count + pushes - pops.
REQ-024 pendX = 1 iff raddrX != 0 and any stored entry has addr == raddrX; combinational, includes entries issuing this cycle.
REQ-025 empty = (count == 0).
REQ-026 No overflow possible: ready rules guarantee push never exceeds free slots; no underflow: pops never exceed count.

Reset
REQ-027 rst_n low asynchronously clears head, tail, count to 0; all stored entries discarded, including mid-drain.
REQ-028 During and after reset: we0=we1=0, waddr/din=0, pend0=pend1=0, empty=1, a_ready=b_ready=1.
REQ-029 Handshakes presented while rst_n low are not accepted.

Verification
REQ-030 Single push: A addr 3 data 16'h1234 at edge N -> next cycle we0=1 waddr0=3 din0=16'h1234, we1=0; following cycle empty=1.
REQ-031 Dual push same cycle: A addr 2 data 16'hAAAA, B addr 5 data 16'h5555 -> next cycle port0=(2,AAAA), port1=(5,5555), then empty.
REQ-032 Coalesce: A addr 4 data 16'h0001, B addr 4 data 16'h0002 same cycle -> next cycle we0=1 waddr0=4 din0=16'h0002, we1=0, count 0 after.
REQ-033 PC gating: push addr F data 16'h0040 with jpc=0 for 3 cycles -> we0=0, pend0=1 for raddr0=F; raise jpc -> we0=1 waddr0=F din0=16'h0040.
REQ-034 Full/backpressure: DEPTH=4, jpc=0, fill with 4 PC writes -> a_ready=0, b_ready=0; after 3 entries b_ready=0, a_ready=1; raise jpc -> two pops per cycle, readies recover.
REQ-035 Reset mid-operation: 3 entries buffered, pull rst_n low between edges -> we0=0, empty=1 immediately; no write issues after release.

Source files
------------

// File: rtl/yd_wbq.sv
// Dual-source write-back queue with dual-port register-file drain,
// PC write gating and hazard lookup.
module yd_wbq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_addr,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_addr,
  input  logic [15:0] b_data,
  input  logic        jpc,
  output logic        we0,
  output logic [3:0]  waddr0,
  output logic [15:0] din0,
  output logic        we1,
  output logic [3:0]  waddr1,
  output logic [15:0] din1,
  input  logic [3:0]  raddr0,
  input  logic [3:0]  raddr1,
  output logic        pend0,
  output logic        pend1,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] PC = 4'hF;

  logic [3:0]    r_addr [DEPTH];
  logic [15:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_h1_ptr;
  logic [3:0]    w_h0_addr;
  logic [3:0]    w_h1_addr;
  logic [15:0]   w_h0_data;
  logic [15:0]   w_h1_data;
  logic          w_a_push;
  logic          w_b_push;
  logic [PW-1:0] w_b_ptr;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [PW-1:0] w_off;

  assign w_h1_ptr  = r_head + PW'(1);
  assign w_h0_addr = r_addr[r_head];
  assign w_h1_addr = r_addr[w_h1_ptr];
  assign w_h0_data = r_data[r_head];
  assign w_h1_data = r_data[w_h1_ptr];

  assign a_ready = r_count < CW'(DEPTH);
  assign b_ready = r_count < CW'(DEPTH - 1);
  assign empty   = r_count == '0;

  // writes to r0 are accepted but never stored
  assign w_a_push = a_valid && a_ready && (a_addr != 4'h0);
  assign w_b_push = b_valid && b_ready && (b_addr != 4'h0);
  assign w_b_ptr  = r_tail + PW'(w_a_push);
  assign w_push   = {1'b0, w_a_push} + {1'b0, w_b_push};

  always_comb begin
    we0    = 1'b0;
    waddr0 = 4'h0;
    din0   = 16'h0;
    we1    = 1'b0;
    waddr1 = 4'h0;
    din1   = 16'h0;
    w_pop  = 2'd0;
    if (r_count == '0) begin
      w_pop = 2'd0;
    end else if (w_h0_addr == PC && !jpc) begin
      w_pop = 2'd0;
    end else if (r_count == CW'(1) ||
                 (w_h1_addr == PC && !jpc)) begin
      we0    = 1'b1;
      waddr0 = w_h0_addr;
      din0   = w_h0_data;
      w_pop  = 2'd1;
    end else if (w_h0_addr == w_h1_addr) begin
      we0    = 1'b1;
      waddr0 = w_h1_addr;
      din0   = w_h1_data;
      w_pop  = 2'd2;
    end else begin
      we0    = 1'b1;
      waddr0 = w_h0_addr;
      din0   = w_h0_data;
      we1    = 1'b1;
      waddr1 = w_h1_addr;
      din1   = w_h1_data;
      w_pop  = 2'd2;
    end
  end

  // hazard lookup spans every live slot, including ones issuing now
  always_comb begin
    pend0 = 1'b0;
    pend1 = 1'b0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if ({1'b0, w_off} < r_count) begin
        if (r_addr[i] == raddr0) pend0 = 1'b1;
        if (r_addr[i] == raddr1) pend1 = 1'b1;
      end
    end
    if (raddr0 == 4'h0) pend0 = 1'b0;
    if (raddr1 == 4'h0) pend1 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_a_push) begin
      r_addr[r_tail] <= a_addr;
      r_data[r_tail] <= a_data;
    end
    if (w_b_push) begin
      r_addr[w_b_ptr] <= b_addr;
      r_data[w_b_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_yd_wbq.sv
// Scoreboard bench for yd_wbq: directed pushes queue expected writes,
// a negedge monitor pops and compares every issued write.
module tb_yd_wbq;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_addr;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_addr;
  logic [15:0] b_data;
  logic        jpc;
  logic        we0;
  logic [3:0]  waddr0;
  logic [15:0] din0;
  logic        we1;
  logic [3:0]  waddr1;
  logic [15:0] din1;
  logic [3:0]  raddr0;
  logic [3:0]  raddr1;
  logic        pend0;
  logic        pend1;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q [$];

  yd_wbq #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data),
    .jpc(jpc),
    .we0(we0), .waddr0(waddr0), .din0(din0),
    .we1(we1), .waddr1(waddr1), .din1(din1),
    .raddr0(raddr0), .raddr1(raddr1),
    .pend0(pend0), .pend1(pend1), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // monitor: pops expected writes in issue order
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0) begin
        if (exp_q.size() == 0)
          chk("unexpected_wr0", 32'({waddr0, din0}), 32'h0);
        else
          chk("port0", 32'({waddr0, din0}),
              32'(exp_q.pop_front()));
      end else begin
        chk("idle0_zero", 32'({waddr0, din0}), 32'h0);
      end
      if (we1) begin
        chk("we1_needs_we0", 32'(we0), 32'h1);
        if (waddr1 == waddr0)
          chk("we1_addr_diff", 32'(waddr1), 32'(~waddr0));
        if (exp_q.size() == 0)
          chk("unexpected_wr1", 32'({waddr1, din1}), 32'h0);
        else
          chk("port1", 32'({waddr1, din1}),
              32'(exp_q.pop_front()));
      end else begin
        chk("idle1_zero", 32'({waddr1, din1}), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_addr  = 4'h0;
    b_addr  = 4'h0;
    a_data  = 16'h0;
    b_data  = 16'h0;
  endtask

  task automatic put_a(logic [3:0] ad, logic [15:0] d);
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic put_b(logic [3:0] ad, logic [15:0] d);
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
  endtask

  initial begin
    rst_n  = 1'b0;
    jpc    = 1'b0;
    raddr0 = 4'h3;
    raddr1 = 4'h0;
    idle_in();
    #3;
    chk("rst_we0", 32'(we0), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'h3);
    chk("rst_pend", 32'({pend0, pend1}), 32'h0);
    #9;
    rst_n = 1'b1;
    step();

    // single push
    put_a(4'h3, 16'h1234);
    exp_q.push_back({4'h3, 16'h1234});
    step();
    idle_in();
    chk("single_we", 32'({we0, we1}), 32'h2);
    chk("single_pend", 32'(pend0), 32'h1);
    step();
    chk("single_empty", 32'(empty), 32'h1);

    // dual push, different addresses
    put_a(4'h2, 16'hAAAA);
    put_b(4'h5, 16'h5555);
    exp_q.push_back({4'h2, 16'hAAAA});
    exp_q.push_back({4'h5, 16'h5555});
    step();
    idle_in();
    chk("dual_we", 32'({we0, we1}), 32'h3);
    step();
    chk("dual_empty", 32'(empty), 32'h1);

    // coalesce
    put_a(4'h4, 16'h0001);
    put_b(4'h4, 16'h0002);
    exp_q.push_back({4'h4, 16'h0002});
    step();
    idle_in();
    chk("coal_we", 32'({we0, we1}), 32'h2);
    step();
    chk("coal_empty", 32'(empty), 32'h1);

    // PC gating
    raddr0 = 4'hF;
    put_a(4'hF, 16'h0040);
    exp_q.push_back({4'hF, 16'h0040});
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("pc_stall_we0", 32'(we0), 32'h0);
      chk("pc_pend0", 32'(pend0), 32'h1);
      step();
    end
    jpc = 1'b1;
    #1;
    chk("pc_issue_we0", 32'(we0), 32'h1);
    step();
    jpc = 1'b0;
    #1;
    chk("pc_empty", 32'(empty), 32'h1);
    chk("pc_pend_clr", 32'(pend0), 32'h0);

    // addr 0 is dropped
    put_a(4'h0, 16'hDEAD);
    step();
    idle_in();
    chk("r0_empty", 32'(empty), 32'h1);
    chk("r0_we0", 32'(we0), 32'h0);

    // older entry issues alone when the younger one is a gated PC write
    raddr0 = 4'h7;
    raddr1 = 4'hF;
    put_a(4'h7, 16'h0777);
    put_b(4'hF, 16'h0FFF);
    exp_q.push_back({4'h7, 16'h0777});
    exp_q.push_back({4'hF, 16'h0FFF});
    step();
    idle_in();
    chk("pcb_we", 32'({we0, we1}), 32'h2);
    chk("pcb_pend", 32'({pend0, pend1}), 32'h3);
    step();
    chk("pcb_stall", 32'(we0), 32'h0);
    chk("pcb_pend_after", 32'({pend0, pend1}), 32'h1);
    jpc = 1'b1;
    step();
    jpc = 1'b0;
    chk("pcb_empty", 32'(empty), 32'h1);

    // fill with gated PC writes
    for (int i = 0; i < 4; i++) begin
      put_a(4'hF, 16'h0100 + 16'(i));
      step();
      case (i)
        0, 1: chk("fill_ready_lo", 32'({a_ready, b_ready}), 32'h3);
        2:    chk("fill_ready_3", 32'({a_ready, b_ready}), 32'h2);
        default: chk("fill_ready_4", 32'({a_ready, b_ready}), 32'h0);
      endcase
    end
    put_a(4'h9, 16'h0999);
    put_b(4'hA, 16'h0AAA);
    step();
    idle_in();
    chk("full_hold", 32'({a_ready, b_ready, empty}), 32'h0);
    exp_q.push_back({4'hF, 16'h0101});
    exp_q.push_back({4'hF, 16'h0103});
    jpc = 1'b1;
    step();
    chk("drain_ready_2", 32'({a_ready, b_ready}), 32'h3);
    step();
    jpc = 1'b0;
    chk("drain_empty", 32'(empty), 32'h1);

    // reset with three gated entries buffered
    put_a(4'hF, 16'h0001);
    put_b(4'hF, 16'h0002);
    step();
    put_a(4'hF, 16'h0003);
    idle_in();
    put_a(4'hF, 16'h0003);
    step();
    idle_in();
    chk("rm_ready_3", 32'({a_ready, b_ready, empty}), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_we0", 32'(we0), 32'h0);
    chk("rm_empty", 32'(empty), 32'h1);
    chk("rm_pend", 32'({pend0, pend1}), 32'h0);
    chk("rm_ready", 32'({a_ready, b_ready}), 32'h3);
    put_a(4'h6, 16'h0666);
    jpc = 1'b1;
    step();
    step();
    idle_in();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rm_after_empty", 32'(empty), 32'h1);
    jpc = 1'b0;

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
